debounce_edge_bank: RTL and testbench

Multi-channel key/pin conditioner for the clock's front-panel inputs. It provides per channel:
- a 2-FF synchroniser
- a stable-time debounce filter
- single-cycle falling/rising edge pulses
- long-press detection with optional auto-repeat

A power-up quiet window suppresses all event pulses until the inputs have settled. Downstream time-set and mode logic consumes the pulses directly.

---
 rtl/clock_pkg.sv | 16 +
 rtl/debounce_channel.sv | 82 ++++++++
 rtl/debounce_edge_bank.sv | 61 ++++++
 tb/tb_debounce_edge_bank.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared defaults and counter sizing for the front-panel input conditioner
package clock_pkg;

  // Defaults assume a 50 MHz clock: 5 ms debounce, 100 us startup, 1 s hold, 200 ms repeat.
  localparam logic        IDLE_LEVEL_DEF      = 1'b1;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 250000;
  localparam int unsigned STARTUP_CYCLES_DEF  = 5000;
  localparam int unsigned HOLD_CYCLES_DEF     = 50000000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 10000000;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int cnt_width(input longint unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one input channel: synchroniser, debounce filter, edge and hold/repeat pulses
module debounce_channel
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter logic        IDLE_LEVEL      = IDLE_LEVEL_DEF
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic Ready,
  input  logic Pin_In,
  output logic H2L_Sig,
  output logic L2H_Sig,
  output logic Hold_Sig,
  output logic Level_Out
);

  localparam int   CW      = cnt_width(DEBOUNCE_CYCLES);
  localparam int   HW      = cnt_width(longint'(HOLD_CYCLES) + longint'(REPEAT_CYCLES));
  localparam logic PRESSED = ~IDLE_LEVEL;

  logic          s1;
  logic          s2;
  logic          db;
  logic [CW-1:0] cnt;
  logic [HW-1:0] hcnt;
  logic          h2l_q;
  logic          l2h_q;
  logic          hold_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      s1     <= IDLE_LEVEL;
      s2     <= IDLE_LEVEL;
      db     <= IDLE_LEVEL;
      cnt    <= '0;
      hcnt   <= '0;
      h2l_q  <= 1'b0;
      l2h_q  <= 1'b0;
      hold_q <= 1'b0;
    end else begin
      s1     <= Pin_In;
      s2     <= s1;
      h2l_q  <= 1'b0;
      l2h_q  <= 1'b0;
      hold_q <= 1'b0;

      // Any sample matching the accepted level restarts the stability count.
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        db    <= s2;
        cnt   <= '0;
        h2l_q <= Ready & ~s2;
        l2h_q <= Ready & s2;
      end else begin
        cnt <= cnt + CW'(1);
      end

      // After the first hold tick hcnt parks at HOLD_CYCLES and, with repeat on, cycles back to it.
      if (db != PRESSED) begin
        hcnt <= '0;
      end else if (HOLD_CYCLES != 0) begin
        if ((hcnt == HW'(HOLD_CYCLES - 1)) ||
            ((REPEAT_CYCLES != 0) && (hcnt == HW'(HOLD_CYCLES + REPEAT_CYCLES - 1)))) begin
          hold_q <= Ready;
          hcnt   <= HW'(HOLD_CYCLES);
        end else if ((hcnt != HW'(HOLD_CYCLES)) || (REPEAT_CYCLES != 0)) begin
          hcnt <= hcnt + HW'(1);
        end
      end
    end
  end

  assign H2L_Sig   = h2l_q;
  assign L2H_Sig   = l2h_q;
  assign Hold_Sig  = hold_q;
  assign Level_Out = db;

endmodule

// File: rtl/debounce_edge_bank.sv
// rtl/debounce_edge_bank.sv - multi-channel key/pin conditioner with power-up quiet window
module debounce_edge_bank
  import clock_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned STARTUP_CYCLES  = STARTUP_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter logic        IDLE_LEVEL      = IDLE_LEVEL_DEF
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [CHANNELS-1:0] Pin_In,
  output logic [CHANNELS-1:0] H2L_Sig,
  output logic [CHANNELS-1:0] L2H_Sig,
  output logic [CHANNELS-1:0] Hold_Sig,
  output logic [CHANNELS-1:0] Level_Out,
  output logic                Ready
);

  localparam int SW = cnt_width(STARTUP_CYCLES);

  logic [SW-1:0] scnt;
  logic          ready_q;

  // Ready latches high on the STARTUP_CYCLES-th clock after release and holds until reset.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      scnt    <= '0;
      ready_q <= (STARTUP_CYCLES == 0);
    end else if (!ready_q) begin
      if (scnt == SW'(STARTUP_CYCLES - 1)) begin
        ready_q <= 1'b1;
      end else begin
        scnt <= scnt + SW'(1);
      end
    end
  end

  assign Ready = ready_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_chan (
      .CLK       (CLK),
      .RSTn      (RSTn),
      .Ready     (ready_q),
      .Pin_In    (Pin_In[i]),
      .H2L_Sig   (H2L_Sig[i]),
      .L2H_Sig   (L2H_Sig[i]),
      .Hold_Sig  (Hold_Sig[i]),
      .Level_Out (Level_Out[i])
    );
  end

endmodule

// File: tb/tb_debounce_edge_bank.sv
// tb/tb_debounce_edge_bank.sv - randomized bench for debounce_edge_bank against a window-rule reference model
module tb_debounce_edge_bank;

  localparam int   CH   = 2;
  localparam int   D    = 4;
  localparam int   S    = 8;
  localparam int   H    = 20;
  localparam int   R    = 5;
  localparam logic IDLE = 1'b1;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [CH-1:0] Pin_In;
  logic [CH-1:0] H2L_Sig;
  logic [CH-1:0] L2H_Sig;
  logic [CH-1:0] Hold_Sig;
  logic [CH-1:0] Level_Out;
  logic          Ready;

  debounce_edge_bank #(
    .CHANNELS        (CH),
    .DEBOUNCE_CYCLES (D),
    .STARTUP_CYCLES  (S),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R),
    .IDLE_LEVEL      (IDLE)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Pin_In    (Pin_In),
    .H2L_Sig   (H2L_Sig),
    .L2H_Sig   (L2H_Sig),
    .Hold_Sig  (Hold_Sig),
    .Level_Out (Level_Out),
    .Ready     (Ready)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: hist holds raw pin samples per clock (newest in bit 0); a level is accepted
  // once the D samples seen through the two sync stages all differ from it.
  logic [CH-1:0] m_db;
  logic [CH-1:0] m_h2l;
  logic [CH-1:0] m_l2h;
  logic [CH-1:0] m_hold;
  logic          m_ready;
  logic [D+1:0]  hist [CH];
  int            plen [CH];
  int            edges;

  task automatic model_reset();
    m_db    = {CH{IDLE}};
    m_h2l   = '0;
    m_l2h   = '0;
    m_hold  = '0;
    m_ready = (S == 0);
    edges   = 0;
    for (int c = 0; c < CH; c++) begin
      hist[c] = {(D+2){IDLE}};
      plen[c] = 0;
    end
  endtask

  task automatic model_edge();
    logic gate;
    logic acc;
    gate    = m_ready;
    edges++;
    m_ready = (edges >= S);
    for (int c = 0; c < CH; c++) begin
      hist[c] = {hist[c][D:0], Pin_In[c]};
      plen[c] = (m_db[c] != IDLE) ? plen[c] + 1 : 0;
      m_hold[c] = gate && (H > 0) && (plen[c] >= H) &&
                  ((R == 0) ? (plen[c] == H) : (((plen[c] - H) % R) == 0));
      acc = (hist[c][D+1:2] == {D{~m_db[c]}});
      m_h2l[c] = gate && acc && m_db[c];
      m_l2h[c] = gate && acc && !m_db[c];
      if (acc) m_db[c] = ~m_db[c];
    end
  endtask

  task automatic compare_all();
    check("level", 32'(Level_Out), 32'(m_db));
    check("h2l",   32'(H2L_Sig),   32'(m_h2l));
    check("l2h",   32'(L2H_Sig),   32'(m_l2h));
    check("hold",  32'(Hold_Sig),  32'(m_hold));
    check("ready", 32'(Ready),     32'(m_ready));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (RSTn) model_edge();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic [CH-1:0] p, input int n);
    repeat (n) begin
      Pin_In = p;
      tick();
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    tick();
    RSTn = 1'b1;
  endtask

  task automatic run_random(input int n);
    int            left [CH];
    logic [CH-1:0] v;
    v = Pin_In;
    for (int c = 0; c < CH; c++) left[c] = 0;
    repeat (n) begin
      for (int c = 0; c < CH; c++) begin
        if (left[c] == 0) begin
          v[c]    = ~v[c];
          left[c] = ($urandom_range(0, 9) < 4) ? int'($urandom_range(1, 5))
                                               : int'($urandom_range(6, 60));
        end
        left[c]--;
      end
      Pin_In = v;
      tick();
      if ($urandom_range(0, 499) == 0) do_reset();
    end
  endtask

  initial begin
    RSTn   = 1'b0;
    Pin_In = {CH{IDLE}};
    model_reset();
    #12;
    compare_all();
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    drive(2'b11, 2);
    drive(2'b10, 40);
    drive(2'b11, 20);

    repeat (6) begin
      drive(2'b01, 3);
      drive(2'b11, 1);
    end
    drive(2'b11, 10);

    drive(2'b00, 70);
    drive(2'b11, 20);
    drive(2'b10, 40);
    drive(2'b11, 20);

    drive(2'b10, 3);
    do_reset();
    drive(2'b11, 15);

    run_random(3000);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
